// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control in front of the instruction ROM.
// Optional redirect counter output is enabled by defining REDIRECT_COUNT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_SIZE  = 256,
    parameter logic [31:0] HALT_WORD = 32'h0000_0073,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] retired
`ifdef REDIRECT_COUNT_EN
    ,
    output logic [31:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT,
        TRAP
    } state_e;

    // Widened by one bit so MEM_SIZE*4 == 2^32 still compares correctly.
    localparam logic [32:0] PC_LIMIT = 33'(MEM_SIZE) * 33'd4;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] next_pc;
    logic        fire;
    logic        is_halt;
    logic        redir;

    assign pc_out   = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign retired  = ret_q;

    assign fire        = (state_q == RUN) && !stall;
    assign is_halt     = (instr_in == HALT_WORD);
    assign redir       = jump | branch_taken;
    assign instr_valid = fire;
    assign instr_out   = fire ? instr_in : NOP_WORD;
    assign halted      = (state_q == HALT);
    assign misaligned  = (state_q == TRAP);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    ret_d = (&ret_q) ? ret_q : ret_q + 32'd1;
                    if (is_halt) begin
                        state_d = HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        state_d = TRAP;
                    end else if ({1'b0, next_pc} >= PC_LIMIT) begin
                        state_d = HALT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ret_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
        end
    end

`ifdef REDIRECT_COUNT_EN
    logic [31:0] rc_q, rc_d;

    // A halt word wins over any redirect, so it never counts as one.
    always_comb begin
        rc_d = rc_q;
        if (fire && !is_halt && redir && !(&rc_q)) begin
            rc_d = rc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q <= 32'd0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign redirect_count = rc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus random episodes.
// Expected outputs come from a behavioural model; a monitor compares each cycle.
module tb_pc_fetch_unit;

    localparam logic [31:0] HALT_W = 32'h0000_0073;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;
    localparam logic [31:0] LIMIT  = 32'd1024;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instr_in;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] retired;
    logic [31:0] redirect_count;

    logic [31:0] rom [0:255];

    assign instr_in = rom[pc_out[9:2]];

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .instr_in      (instr_in),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .misaligned    (misaligned),
        .retired       (retired)
`ifdef REDIRECT_COUNT_EN
        ,
        .redirect_count(redirect_count)
`endif
    );

`ifndef REDIRECT_COUNT_EN
    assign redirect_count = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] io;
        logic [31:0] ret;
        logic [31:0] rc;
        logic        v;
        logic        h;
        logic        m;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    logic [31:0] mpc;
    logic [31:0] mret;
    logic [31:0] mrc;
    bit          mboot;
    bit          mhalt;
    bit          mtrap;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_out", pc_out, e.pc);
            chk("pc_plus4", pc_plus4, e.p4);
            chk("instr_out", instr_out, e.io);
            chk("instr_valid", 32'(instr_valid), 32'(e.v));
            chk("halted", 32'(halted), 32'(e.h));
            chk("misaligned", 32'(misaligned), 32'(e.m));
            chk("retired", retired, e.ret);
`ifdef REDIRECT_COUNT_EN
            chk("redirect_count", redirect_count, e.rc);
`endif
        end
    end

    task automatic model_init();
        mpc   = 32'd0;
        mret  = 32'd0;
        mrc   = 32'd0;
        mboot = 1'b1;
        mhalt = 1'b0;
        mtrap = 1'b0;
    endtask

    // Drive one cycle, queue expected outputs, advance model, wait an edge.
    task automatic step(input bit st, input bit j, input logic [31:0] jt,
                        input bit b, input logic [31:0] bt);
        exp_t        e;
        logic [31:0] word;
        logic [31:0] nxt;
        bit          run;
        stall         = st;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        word = rom[mpc[9:2]];
        run  = !mboot && !mhalt && !mtrap;
        e.pc  = mpc;
        e.p4  = mpc + 32'd4;
        e.v   = run && !st;
        e.io  = (run && !st) ? word : NOP_W;
        e.h   = mhalt;
        e.m   = mtrap;
        e.ret = mret;
        e.rc  = mrc;
        exp_q.push_back(e);
        if (mboot) begin
            mboot = 1'b0;
        end else if (run && !st) begin
            if (mret != 32'hFFFF_FFFF) mret = mret + 1;
            if (word == HALT_W) begin
                mhalt = 1'b1;
            end else begin
                nxt = j ? jt : (b ? bt : mpc + 32'd4);
                if ((j || b) && mrc != 32'hFFFF_FFFF) mrc = mrc + 1;
                if (nxt % 4 != 0) mtrap = 1'b1;
                else if (nxt >= LIMIT) mhalt = 1'b1;
                else mpc = nxt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Asynchronous reset pulse asserted in the middle of a cycle.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);
        chk("rst_ret", retired, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_init();
    endtask

    function automatic logic [31:0] rtgt();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
        if (r == 1) return LIMIT + 32'($urandom_range(0, 255) * 4);
        return 32'($urandom_range(0, 255) * 4);
    endfunction

    initial begin
        stall = 0; jump = 0; branch_taken = 0;
        jump_target = 0; branch_target = 0;
        for (int i = 0; i < 256; i++) rom[i] = NOP_W;
        model_init();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Sequential fetch, jump-over-branch priority, stall, misaligned trap
        do_reset();
        idle(5);
        step(0, 1, 32'h40, 1, 32'h80);
        step(0, 1, 32'h20, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1, 32'h100);
        step(0, 0, 32'h0, 1, 32'h100);
        step(0, 1, 32'h8, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h6);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h40, 0, 32'h0);

        // Run off the end of the ROM
        do_reset();
        idle(1 + 256 + 3);

        // Halt word at 0x14, later branch ignored
        rom[5] = HALT_W;
        do_reset();
        idle(1 + 6);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 32'h40);
        rom[5] = NOP_W;

        // Random episodes
        for (int ep = 0; ep < 25; ep++) begin
            for (int i = 0; i < 256; i++) begin
                logic [31:0] w;
                w = $urandom;
                if (w == HALT_W || $urandom_range(0, 47) == 0) w = HALT_W;
                rom[i] = w;
            end
            do_reset();
            for (int c = 0; c < 80; c++) begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     rtgt(), $urandom_range(0, 4) == 0, rtgt());
            end
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage directly upstream of the instruction ROM in the single-cycle core. Holds the PC and drives it to the ROM byte address. Takes the ROM word back, qualifies it, and hands it to decode. Selects next PC (sequential / branch / jump), supports stall, and stops the core on a halt word, PC overrun, or a misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_SIZE, 256, ROM depth in 32-bit words; the last valid PC is MEM_SIZE*4-4
HALT_WORD, 32'h0000_0073, instruction encoding that halts fetch (ecall)
NOP_WORD, 32'h0000_0013, word presented to decode when not valid (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC and retire nothing this cycle
branch_taken  input  1  redirect to branch_target
branch_target  input  32  branch destination byte address
jump  input  1  redirect to jump_target (jal/jalr)
jump_target  input  32  jump destination byte address
pc_out  output  32  current PC; connects to the ROM address input
pc_plus4  output  32  pc_out + 4, for link register
instr_in  input  32  word returned by the ROM for pc_out
instr_out  output  32  instruction to decode
instr_valid  output  1  instr_out is a real instruction
halted  output  1  fetch stopped by halt word or PC overrun
misaligned  output  1  fetch stopped by a target with bits[1:0] != 0
retired  output  32  count of instructions retired

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - pc_out = RESET_PC; state = BOOT; halted = 0; misaligned = 0; retired = 0; instr_valid = 0.
- States:
  - BOOT: one cycle after reset release, instr_valid = 0, PC holds. Always goes to RUN next.
  - RUN: normal fetch.
  - HALT: terminal.
  - TRAP: terminal.
- Only rst_n leaves HALT or TRAP.
- instr_valid = (state == RUN) and !stall. instr_out = instr_in when instr_valid, else NOP_WORD. Both are combinational.
- pc_plus4 is combinational, wraps mod 2^32.
- In RUN with stall=0, on a rising edge, evaluate in this priority order:
  1. If instr_in == HALT_WORD: go to HALT, halted = 1, PC holds. The halt word counts as retired.
  2. If jump: next = jump_target.
  3. Else if branch_taken: next = branch_target.
  4. Else: next = pc_out + 4.
  5. If next[1:0] != 0: go to TRAP, misaligned = 1, PC holds at the faulting instruction.
  6. Else if next >= MEM_SIZE*4: go to HALT, halted = 1, PC holds.
  7. Else: pc_out <= next.
- retired increments on every RUN cycle with stall=0, including the cycle that causes HALT or TRAP. It saturates at 32'hFFFF_FFFF.
- stall=1 in RUN: PC, state and retired all hold. Redirects presented during a stall are ignored; the requester must hold them until stall drops.
- jump and branch_taken both high: jump wins.
- In BOOT/HALT/TRAP, stall, jump and branch are ignored.
- rst_n asserted mid-operation clears everything immediately, independent of clk.

Optional Feature:
REDIRECT_COUNT_EN
- Defined:
  - Adds output redirect_count [31:0], reset to 0.
  - It increments (saturating) on each RUN non-stalled cycle in which jump or branch_taken selects next, including a redirect that then traps or halts.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset release, instr_in = 32'h0000_0013, no redirects, 4 cycles:
  - BOOT cycle: instr_valid = 0.
  - Then pc_out = 0x0, 0x4, 0x8, 0xC over successive cycles.
  - retired = 3 after the third RUN edge.
  - pc_plus4 = pc_out + 4 throughout.
- At pc_out = 0x10, assert jump = 1 (jump_target = 0x40) together with branch_taken = 1 (branch_target = 0x80):
  - Next pc_out = 0x40 (jump wins).
  - With REDIRECT_COUNT_EN, redirect_count = 1.
- At pc_out = 0x20, assert stall = 1 for 3 cycles together with branch_taken = 1 (branch_target = 0x100):
  - pc_out stays 0x20, instr_valid = 0, instr_out = 0x0000_0013, retired unchanged.
  - Release stall with the branch still held: pc_out = 0x100 on the next edge.
- At pc_out = 0x8, assert branch_taken = 1 with branch_target = 0x0000_0006:
  - misaligned = 1 and pc_out stays 0x8.
  - Further cycles with jump = 1: no change.
  - Pulse rst_n low mid-cycle: pc_out = 0x0 and misaligned = 0 immediately.
- Sequential run to pc_out = 0x3FC (MEM_SIZE = 256):
  - On the next edge halted = 1 and pc_out stays 0x3FC.
  - instr_valid = 0 afterwards; retired = 256.
- At pc_out = 0x14, drive instr_in = 32'h0000_0073:
  - halted = 1 and pc_out stays 0x14; retired counts the halt word.
  - Subsequent branch_taken = 1 is ignored.
